// File: rtl/boot_pkg.sv
// boot_pkg: shared types and the pattern generator used by the boot loader write and verify paths
package boot_pkg;
  typedef enum logic [1:0] {PAT_INC, PAT_FILL, PAT_XOR} pattern_e;
  typedef enum logic [2:0] {IDLE, WRITE, VERIFY, DRAIN, DONE} state_e;
  function automatic logic [31:0] boot_pattern(pattern_e mode, logic [31:0] init, logic [31:0] index, logic [31:0] addr);
    return mode == PAT_INC ? init + index : mode == PAT_FILL ? init : addr ^ init;
  endfunction
endpackage

// File: rtl/boot_check_pipe.sv
// boot_check_pipe: carries each read's expected word and address until its BSRAM data returns, then compares
module boot_check_pipe #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] expected,
  input  logic [DATA_W-1:0] rd_data,
  output logic              mismatch,
  output logic [ADDR_W-1:0] mismatch_addr
);
  logic              v [DEPTH];
  logic [DATA_W-1:0] e [DEPTH];
  logic [ADDR_W-1:0] a [DEPTH];
  // shift the read tags one stage per clock, in step with the BSRAM output pipeline
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        v[i] <= 1'b0;
        e[i] <= '0;
        a[i] <= '0;
      end
    end else begin
      v[0] <= valid;
      e[0] <= expected;
      a[0] <= addr;
      for (int i = 1; i < DEPTH; i++) begin
        v[i] <= v[i-1];
        e[i] <= e[i-1];
        a[i] <= a[i-1];
      end
    end
  assign mismatch      = v[DEPTH-1] && rd_data != e[DEPTH-1];
  assign mismatch_addr = a[DEPTH-1];
endmodule

// File: rtl/bsram_boot_loader.sv
// bsram_boot_loader: power-on pattern fill and optional read-back check of a simple-dual-port BSRAM
module bsram_boot_loader
  import boot_pkg::*;
#(
  parameter int       ADDR_W     = 13,
  parameter int       DATA_W     = 8,
  parameter int       BASE_ADDR  = 'h0200,
  parameter int       LENGTH     = 128,
  parameter pattern_e MODE       = PAT_INC,
  parameter int       INIT_VALUE = 'h00,
  parameter bit       VERIFY     = 1'b1,
  parameter int       RD_LATENCY = 2,
  parameter bit       AUTO_START = 1'b1
) (
  input  logic              MEMORY_CLK,
  input  logic              rst_n,
  input  logic              start,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              boot_mode,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr,
  output logic [15:0]       err_count
);
  localparam int IW = $clog2(LENGTH + 1);
  state_e            state, state_d;
  logic [IW-1:0]     idx, n_idx;
  logic [1:0]        dcnt;
  logic [ADDR_W-1:0] n_addr, chk_addr;
  logic [DATA_W-1:0] n_pat, rd_exp;
  logic              last, restart, mismatch;
  assign last    = idx == IW'(LENGTH - 1);
  assign restart = state == DONE && start;
  assign n_idx   = (state == WRITE && !last) || state == boot_pkg::VERIFY ? idx + IW'(1) : '0;
  assign n_addr  = ADDR_W'(BASE_ADDR + 32'(n_idx));
  assign n_pat   = DATA_W'(boot_pattern(MODE, 32'(INIT_VALUE), 32'(n_idx), 32'(n_addr)));
  // state register
  always_ff @(posedge MEMORY_CLK or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  // next state; a write-only run spends a single cycle in DRAIN before DONE
  always_comb begin
    state_d = state;
    case (state)
      IDLE:             state_d = AUTO_START || start ? WRITE : IDLE;
      WRITE:            state_d = !last ? WRITE : VERIFY ? boot_pkg::VERIFY : DRAIN;
      boot_pkg::VERIFY: state_d = last ? DRAIN : boot_pkg::VERIFY;
      DRAIN:            state_d = dcnt == 2'(RD_LATENCY - 1) || !VERIFY ? DONE : DRAIN;
      default:          state_d = start ? WRITE : DONE;
    endcase
  end
  // registered memory-port outputs, word index and drain counter follow the next state
  always_ff @(posedge MEMORY_CLK or negedge rst_n)
    if (!rst_n) begin
      idx       <= '0;
      dcnt      <= '0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      wr_addr   <= ADDR_W'(BASE_ADDR);
      rd_addr   <= ADDR_W'(BASE_ADDR);
      wr_data   <= '0;
      rd_exp    <= '0;
      boot_mode <= 1'b1;
      done      <= 1'b0;
    end else begin
      wr_en     <= state_d == WRITE;
      rd_en     <= state_d == boot_pkg::VERIFY;
      boot_mode <= state_d != DONE;
      done      <= state_d == DONE;
      dcnt      <= state == DRAIN ? dcnt + 2'd1 : 2'd0;
      if (state_d == WRITE || state_d == boot_pkg::VERIFY) idx <= n_idx;
      if (state_d == WRITE) begin
        wr_addr <= n_addr;
        wr_data <= n_pat;
      end
      if (state_d == boot_pkg::VERIFY) begin
        rd_addr <= n_addr;
        rd_exp  <= n_pat;
      end
    end
  boot_check_pipe #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(RD_LATENCY)) u_check (
    .clk          (MEMORY_CLK),
    .rst_n        (rst_n),
    .valid        (rd_en),
    .addr         (rd_addr),
    .expected     (rd_exp),
    .rd_data      (rd_data),
    .mismatch     (mismatch),
    .mismatch_addr(chk_addr)
  );
  // sticky error flag, saturating count and first-failure address; a restart clears them
  always_ff @(posedge MEMORY_CLK or negedge rst_n)
    if (!rst_n) begin
      error     <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else if (restart) begin
      error     <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else if (mismatch) begin
      error     <= 1'b1;
      err_count <= err_count + 16'(err_count != 16'hFFFF);
      if (!error) err_addr <= chk_addr;
    end
endmodule

// File: tb/tb_bsram_boot_loader.sv
// tb_bsram_boot_loader: three boot loader configurations driven against behavioural SDPB memory models
module tb_bsram_boot_loader;
  localparam int N = 8192;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int compared = 0, mismatched = 0;

  // instance A: default parameters, memory with injectable read corruption
  logic a_rst_n = 1'b0, a_start = 1'b0, a_wr_en, a_rd_en, a_boot_mode, a_done, a_error;
  logic [12:0] a_wr_addr, a_rd_addr, a_err_addr;
  logic [7:0] a_wr_data, a_rd_data, a_p1, a_p2;
  logic [15:0] a_err_count;
  logic [7:0] a_mem [N];
  bit a_bad [N];
  int a_cyc, a_done_at = -1;
  int a_log[$];
  bsram_boot_loader dut_a (.MEMORY_CLK(clk), .rst_n(a_rst_n), .start(a_start), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .boot_mode(a_boot_mode),
    .done(a_done), .error(a_error), .err_addr(a_err_addr), .err_count(a_err_count));
  always @(posedge clk) begin
    if (a_wr_en) a_mem[a_wr_addr] <= a_wr_data;
    if (a_rd_en) a_p1 <= a_mem[a_rd_addr] ^ (a_bad[a_rd_addr] ? 8'hFF : 8'h00);
    a_p2 <= a_p1;
  end
  assign a_rd_data = a_p2;
  always @(posedge clk or negedge a_rst_n) a_cyc <= !a_rst_n ? 0 : a_cyc + 1;
  always @(negedge clk) begin
    if (a_wr_en) a_log.push_back(int'({a_wr_addr, a_wr_data}));
    if (a_done && a_done_at < 0) a_done_at = a_cyc;
  end

  // instance B: FILL 0xA5 across the top-of-memory wrap
  logic b_rst_n = 1'b0, b_wr_en, b_rd_en, b_boot_mode, b_done, b_error;
  logic [12:0] b_wr_addr, b_rd_addr, b_err_addr;
  logic [7:0] b_wr_data, b_rd_data, b_p1, b_p2;
  logic [15:0] b_err_count;
  logic [7:0] b_mem [N];
  int b_cyc, b_done_at = -1;
  int b_log[$];
  bsram_boot_loader #(.BASE_ADDR('h1FF0), .LENGTH(32), .MODE(boot_pkg::PAT_FILL), .INIT_VALUE('hA5)) dut_b (
    .MEMORY_CLK(clk), .rst_n(b_rst_n), .start(1'b0), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .boot_mode(b_boot_mode), .done(b_done),
    .error(b_error), .err_addr(b_err_addr), .err_count(b_err_count));
  always @(posedge clk) begin
    if (b_wr_en) b_mem[b_wr_addr] <= b_wr_data;
    if (b_rd_en) b_p1 <= b_mem[b_rd_addr];
    b_p2 <= b_p1;
  end
  assign b_rd_data = b_p2;
  always @(posedge clk or negedge b_rst_n) b_cyc <= !b_rst_n ? 0 : b_cyc + 1;
  always @(negedge clk) begin
    if (b_wr_en) b_log.push_back(int'({b_wr_addr, b_wr_data}));
    if (b_done && b_done_at < 0) b_done_at = b_cyc;
  end

  // instance C: manual start, write only, XOR key 0x0F, single-cycle read latency
  logic c_rst_n = 1'b0, c_start = 1'b0, c_wr_en, c_rd_en, c_boot_mode, c_done, c_error;
  logic [12:0] c_wr_addr, c_rd_addr, c_err_addr;
  logic [7:0] c_wr_data, c_rd_data, c_p1;
  logic [15:0] c_err_count;
  logic [7:0] c_mem [N];
  bit c_rd_seen = 1'b0;
  int c_cyc, c_done_at = -1;
  int c_log[$];
  bsram_boot_loader #(.MODE(boot_pkg::PAT_XOR), .INIT_VALUE('h0F), .VERIFY(1'b0), .RD_LATENCY(1), .AUTO_START(1'b0)) dut_c (
    .MEMORY_CLK(clk), .rst_n(c_rst_n), .start(c_start), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
    .rd_en(c_rd_en), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .boot_mode(c_boot_mode), .done(c_done),
    .error(c_error), .err_addr(c_err_addr), .err_count(c_err_count));
  always @(posedge clk) begin
    if (c_wr_en) c_mem[c_wr_addr] <= c_wr_data;
    if (c_rd_en) c_p1 <= c_mem[c_rd_addr];
  end
  assign c_rd_data = c_p1;
  always @(posedge clk or negedge c_rst_n) c_cyc <= !c_rst_n ? 0 : c_cyc + 1;
  always @(negedge clk) begin
    if (c_wr_en) c_log.push_back(int'({c_wr_addr, c_wr_data}));
    if (c_rd_en) c_rd_seen = 1'b1;
    if (c_done && c_done_at < 0) c_done_at = c_cyc;
  end

  // reference write sequence: count of log entries that differ from the specified address/data list
  function automatic int log_errors(input int q[$], input int mode, input int init, input int base, input int len);
    int bad = q.size() != len ? 1 : 0;
    for (int i = 0; i < q.size() && i < len; i++) begin
      int addr = (base + i) % N;
      int data = mode == 0 ? (init + i) % 256 : mode == 1 ? init : (addr % 256) ^ init;
      if (q[i] != addr * 256 + data) bad++;
    end
    return bad;
  endfunction

  task automatic wait_a(input int lim);
    int n = 0;
    while (!a_done && n < lim) begin @(negedge clk); n++; end
    #1;
    compared++;
    if (a_done !== 1'b1) begin mismatched++; $display("FAIL a_done_timeout: done=%0b after %0d cycles, want 1", a_done, n); end
  endtask

  task automatic restart_a(output int k);
    @(negedge clk); #1;
    k = a_cyc; a_log.delete(); a_done_at = -1; a_start = 1'b1;
    @(negedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    compared++;
    if ({a_wr_en, a_rd_en, a_wr_addr, a_rd_addr, a_wr_data, a_boot_mode, a_done, a_error, a_err_addr, a_err_count} !==
        {2'b00, 13'h0200, 13'h0200, 8'h00, 3'b100, 13'h0000, 16'h0000}) begin
      mismatched++; $display("FAIL reset_a: got %h want %h", {a_wr_en, a_rd_en, a_wr_addr, a_rd_addr, a_wr_data, a_boot_mode,
        a_done, a_error, a_err_addr, a_err_count}, {2'b00, 13'h0200, 13'h0200, 8'h00, 3'b100, 13'h0000, 16'h0000});
    end
    compared++;
    if ({b_wr_en, b_rd_en, b_wr_addr, b_rd_addr, b_boot_mode, b_done, b_error, b_err_count} !==
        {2'b00, 13'h1FF0, 13'h1FF0, 3'b100, 16'h0000}) begin
      mismatched++; $display("FAIL reset_b: got %h want %h", {b_wr_en, b_rd_en, b_wr_addr, b_rd_addr, b_boot_mode, b_done,
        b_error, b_err_count}, {2'b00, 13'h1FF0, 13'h1FF0, 3'b100, 16'h0000});
    end
    compared++;
    if ({c_wr_en, c_rd_en, c_wr_addr, c_wr_data, c_boot_mode, c_done, c_error} !== {2'b00, 13'h0200, 8'h00, 3'b100}) begin
      mismatched++; $display("FAIL reset_c: got %h want %h", {c_wr_en, c_rd_en, c_wr_addr, c_wr_data, c_boot_mode, c_done,
        c_error}, {2'b00, 13'h0200, 8'h00, 3'b100});
    end
  endtask

  task automatic test_default_run;
    int bad;
    @(negedge clk); #1;
    a_log.delete(); a_done_at = -1; a_rst_n = 1'b1;
    wait_a(400);
    bad = log_errors(a_log, 0, 'h00, 'h200, 128);
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL default_writes: %0d bad of %0d logged, want 0 bad of 128", bad, a_log.size()); end
    compared++;
    if (a_done_at !== 259) begin mismatched++; $display("FAIL default_done_edge: got %0d want 259", a_done_at); end
    repeat (5) @(negedge clk);
    compared++;
    if ({a_done, a_boot_mode, a_error, a_err_count, a_wr_en, a_rd_en} !== {3'b100, 16'h0, 2'b00}) begin
      mismatched++; $display("FAIL default_done_state: got %h want %h", {a_done, a_boot_mode, a_error, a_err_count, a_wr_en, a_rd_en},
        {3'b100, 16'h0, 2'b00});
    end
  endtask

  task automatic test_start_ignored;
    int k, bad;
    int t[4];
    a_bad[13'h0205] = 1'b1; a_bad[13'h0210] = 1'b1;
    restart_a(k);
    compared++;
    if ({a_done, a_boot_mode, a_wr_en, a_wr_addr} !== {3'b011, 13'h0200}) begin
      mismatched++; $display("FAIL restart_first_word: got %h want %h", {a_done, a_boot_mode, a_wr_en, a_wr_addr}, {3'b011, 13'h0200});
    end
    t = '{k + 1 + $urandom_range(1, 126), k + 128, k + 129 + $urandom_range(0, 127), k + 257};
    foreach (t[i]) begin
      while (a_cyc < t[i]) begin @(negedge clk); #1; end
      a_start = 1'b1;
      @(negedge clk); #1;
      a_start = 1'b0;
    end
    wait_a(300);
    bad = log_errors(a_log, 0, 'h00, 'h200, 128);
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL ignored_starts_writes: %0d bad of %0d logged, want 0", bad, a_log.size()); end
    compared++;
    if (a_done_at !== k + 259) begin mismatched++; $display("FAIL ignored_starts_done_edge: got %0d want %0d", a_done_at, k + 259); end
    compared++;
    if ({a_error, a_err_addr, a_err_count} !== {1'b1, 13'h0205, 16'd2}) begin
      mismatched++; $display("FAIL corrupt_fixed: got %h want %h", {a_error, a_err_addr, a_err_count}, {1'b1, 13'h0205, 16'd2});
    end
  endtask

  task automatic test_rerun_clears;
    int k, n, cnt, lo, ix;
    a_bad = '{default: 1'b0};
    n = $urandom_range(1, 6); cnt = 0; lo = 128;
    for (int i = 0; i < n; i++) begin
      ix = $urandom_range(0, 127);
      if (!a_bad[(ix + 'h200) % N]) cnt++;
      a_bad[(ix + 'h200) % N] = 1'b1;
      if (ix < lo) lo = ix;
    end
    restart_a(k);
    compared++;
    if ({a_error, a_err_addr, a_err_count} !== 30'h0) begin
      mismatched++; $display("FAIL rerun_clear: got %h want 0", {a_error, a_err_addr, a_err_count});
    end
    wait_a(300);
    compared++;
    if ({a_error, a_err_addr, a_err_count} !== {1'b1, 13'('h200 + lo), 16'(cnt)}) begin
      mismatched++; $display("FAIL corrupt_random: got %h want %h", {a_error, a_err_addr, a_err_count}, {1'b1, 13'('h200 + lo), 16'(cnt)});
    end
    compared++;
    if (a_done_at !== k + 259) begin mismatched++; $display("FAIL rerun_done_edge: got %0d want %0d", a_done_at, k + 259); end
    a_bad = '{default: 1'b0};
  endtask

  task automatic test_reset_midrun;
    int k, n = 0, bad;
    restart_a(k);
    while (a_log.size() < 40 && n < 100) begin @(negedge clk); #1; n++; end
    #1 a_rst_n = 1'b0;
    #1;
    compared++;
    if ({a_wr_en, a_rd_en, a_boot_mode, a_done, a_wr_addr} !== {4'b0010, 13'h0200}) begin
      mismatched++; $display("FAIL async_reset: got %h want %h", {a_wr_en, a_rd_en, a_boot_mode, a_done, a_wr_addr}, {4'b0010, 13'h0200});
    end
    @(negedge clk); #1;
    a_log.delete(); a_done_at = -1; a_rst_n = 1'b1;
    wait_a(400);
    bad = log_errors(a_log, 0, 'h00, 'h200, 128);
    compared++;
    if (bad !== 0 || a_done_at !== 259) begin
      mismatched++; $display("FAIL reset_rerun: bad=%0d done_edge=%0d want bad=0 done_edge=259", bad, a_done_at);
    end
  endtask

  task automatic test_wrap;
    int n = 0, bad;
    @(negedge clk); #1;
    b_rst_n = 1'b1;
    while (!b_done && n < 200) begin @(negedge clk); n++; end
    #1;
    bad = log_errors(b_log, 1, 'hA5, 'h1FF0, 32);
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL wrap_writes: %0d bad of %0d logged, want 0 bad of 32", bad, b_log.size()); end
    compared++;
    if ({b_done, b_error, b_err_count} !== {2'b10, 16'h0} || b_done_at !== 67) begin
      mismatched++; $display("FAIL wrap_done: done=%0b error=%0b count=%0d edge=%0d want 1 0 0 67", b_done, b_error, b_err_count, b_done_at);
    end
  endtask

  task automatic test_xor_manual;
    int k, n = 0, bad;
    @(negedge clk); #1;
    c_rst_n = 1'b1;
    repeat (20 + $urandom_range(0, 10)) @(negedge clk);
    #1;
    compared++;
    if ({c_wr_en, c_boot_mode, c_done} !== 3'b010 || c_log.size() !== 0) begin
      mismatched++; $display("FAIL manual_idle: wr_en=%0b boot_mode=%0b done=%0b writes=%0d want 0 1 0 0", c_wr_en, c_boot_mode, c_done, c_log.size());
    end
    k = c_cyc; c_start = 1'b1;
    @(negedge clk); #1;
    c_start = 1'b0;
    while (!c_done && n < 300) begin @(negedge clk); n++; end
    #1;
    bad = log_errors(c_log, 2, 'h0F, 'h200, 128);
    compared++;
    if (bad !== 0 || c_log[0] !== int'(21'h02000F) || c_log[1] !== int'(21'h02010E)) begin
      mismatched++; $display("FAIL xor_writes: bad=%0d first=%h second=%h want 0 02000f 02010e", bad, c_log[0], c_log[1]);
    end
    compared++;
    if (c_done_at !== k + 130 || c_rd_seen !== 1'b0 || c_error !== 1'b0) begin
      mismatched++; $display("FAIL xor_done: edge=%0d rd_seen=%0b error=%0b want %0d 0 0", c_done_at, c_rd_seen, c_error, k + 130);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_default_run;
    test_start_ignored;
    test_rerun_clears;
    test_reset_midrun;
    test_wrap;
    test_xor_manual;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
